// File: rtl/uart_link_tester_if.sv
// FIFO-side handshake between the link tester and the UART(s) under test.
// master: the tester (drives the TX write port, pops the RX read port).
// slave:  the UART FIFO side.
interface uart_link_tester_if #(
  parameter int unsigned DBIT = 8
) ();
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;

  modport master (
    input  tx_full,
    output wr_uart,
    output w_data,
    input  rx_empty,
    input  r_data,
    output rd_uart
  );

  modport slave (
    output tx_full,
    input  wr_uart,
    input  w_data,
    output rx_empty,
    output r_data,
    input  rd_uart
  );
endinterface

// File: rtl/uart_link_tester.sv
// UART link traffic generator and checker.
// Writes a counter or LFSR pattern into the TX FIFO, pops the RX FIFO and
// compares each word against the regenerated pattern; reports error count,
// timeout and pass/fail. Optional first-mismatch capture is built when the
// macro UART_LT_FIRST_ERR_EN is defined; otherwise those ports read 0.
module uart_link_tester #(
  parameter int unsigned    DBIT      = 8,
  parameter int unsigned    BURST_W   = 8,
  parameter int unsigned    TO_W      = 20,
  parameter int unsigned    TIMEOUT   = 1000000,
  parameter logic [DBIT-1:0] SEED      = DBIT'(1),
  parameter logic [DBIT-1:0] LFSR_TAPS = DBIT'(8'hB8)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [BURST_W-1:0] i_burst_len,
  uart_link_tester_if.master io_uart,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [BURST_W-1:0] o_err_cnt,
  output logic [BURST_W-1:0] o_first_err_idx,
  output logic [DBIT-1:0]    o_first_err_exp,
  output logic [DBIT-1:0]    o_first_err_got
);

  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_mode;
  logic [BURST_W-1:0] r_len;
  logic [DBIT-1:0]    r_tx_pat;
  logic [DBIT-1:0]    r_rx_pat;
  logic [BURST_W-1:0] r_sent;
  logic [BURST_W-1:0] r_rcvd;
  logic [BURST_W-1:0] r_err_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_pass;
  logic               r_timeout;

  logic w_run;
  logic w_start;
  logic w_wr;
  logic w_rd;
  logic w_mismatch;
  logic w_to_hit;

  // Counter mode wraps modulo 2^DBIT; LFSR mode is a right-shifting Galois LFSR.
  function automatic logic [DBIT-1:0] f_advance(input logic mode, input logic [DBIT-1:0] p);
    if (mode) begin
      return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
    end
    return p + DBIT'(1);
  endfunction

  assign w_run      = (r_state == StRun);
  assign w_start    = (r_state == StIdle) && i_start;
  assign w_wr       = w_run && !io_uart.tx_full && (r_sent != r_len);
  assign w_rd       = w_run && !io_uart.rx_empty && (r_rcvd != r_len);
  assign w_mismatch = w_rd && (io_uart.r_data != r_rx_pat);
  // Idle limit reached in a cycle without a pop and with words still outstanding.
  assign w_to_hit   = w_run && !w_rd && (r_rcvd != r_len) && (r_to_cnt == TimeoutLast);

  assign io_uart.wr_uart = w_wr;
  assign io_uart.w_data  = r_tx_pat;
  assign io_uart.rd_uart = w_rd;

  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StFin);
  assign o_pass    = r_pass;
  assign o_timeout = r_timeout;
  assign o_err_cnt = r_err_cnt;

  // State register; synchronous reset aborts any run without a done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = StRun;
      StRun:   if ((r_rcvd == r_len) || w_to_hit) w_state_nxt = StFin;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Run datapath: latch config at start, generate TX, check RX, track idle time.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_mode    <= 1'b0;
      r_len     <= '0;
      r_tx_pat  <= '0;
      r_rx_pat  <= '0;
      r_sent    <= '0;
      r_rcvd    <= '0;
      r_err_cnt <= '0;
      r_to_cnt  <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_mode    <= i_mode;
      r_len     <= i_burst_len;
      r_tx_pat  <= SEED;
      r_rx_pat  <= SEED;
      r_sent    <= '0;
      r_rcvd    <= '0;
      r_err_cnt <= '0;
      r_to_cnt  <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_run) begin
      if (w_wr) begin
        r_sent   <= r_sent + BURST_W'(1);
        r_tx_pat <= f_advance(r_mode, r_tx_pat);
      end
      if (w_rd) begin
        r_rcvd   <= r_rcvd + BURST_W'(1);
        r_rx_pat <= f_advance(r_mode, r_rx_pat);
        r_to_cnt <= '0;
        if (w_mismatch && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + BURST_W'(1);
        end
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end else if (r_state == StFin) begin
      r_pass <= !r_timeout && (r_err_cnt == '0);
    end
  end

`ifdef UART_LT_FIRST_ERR_EN
  logic [BURST_W-1:0] r_fe_idx;
  logic [DBIT-1:0]    r_fe_exp;
  logic [DBIT-1:0]    r_fe_got;

  // Capture only the first mismatch of a run; err_cnt is still zero at that point.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_fe_idx <= '0;
      r_fe_exp <= '0;
      r_fe_got <= '0;
    end else if (w_start) begin
      r_fe_idx <= '0;
      r_fe_exp <= '0;
      r_fe_got <= '0;
    end else if (w_mismatch && (r_err_cnt == '0)) begin
      r_fe_idx <= r_rcvd;
      r_fe_exp <= r_rx_pat;
      r_fe_got <= io_uart.r_data;
    end
  end

  assign o_first_err_idx = r_fe_idx;
  assign o_first_err_exp = r_fe_exp;
  assign o_first_err_got = r_fe_got;
`else
  assign o_first_err_idx = '0;
  assign o_first_err_exp = '0;
  assign o_first_err_got = '0;
`endif

endmodule

// File: tb/tb_uart_link_tester.sv
// Bench for uart_link_tester: a loopback FIFO model with a few cycles of line
// latency, optional corruption of one word and an option to drop all RX
// traffic. Expected TX words are queued at start and popped on each write.
module tb_uart_link_tester;

  localparam int unsigned Timeout = 100;
  localparam int          LineLat = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;
  logic       pass;
  logic       tmo;
  logic [7:0] err_cnt;
  logic [7:0] fe_idx;
  logic [7:0] fe_exp;
  logic [7:0] fe_got;

  always #5 clk = ~clk;

  uart_link_tester_if #(.DBIT(8)) u_if ();

  uart_link_tester #(
    .DBIT    (8),
    .BURST_W (8),
    .TO_W    (20),
    .TIMEOUT (Timeout)
  ) u_dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_start         (start),
    .i_mode          (mode),
    .i_burst_len     (burst_len),
    .io_uart         (u_if.master),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_timeout       (tmo),
    .o_err_cnt       (err_cnt),
    .o_first_err_idx (fe_idx),
    .o_first_err_exp (fe_exp),
    .o_first_err_got (fe_got)
  );

  int         n_chk;
  int         n_err;
  int         cyc;
  logic [7:0] exp_q[$];
  logic [7:0] line_d[$];
  int         line_t[$];
  logic [7:0] rx_q[$];
  int         sent_n;
  int         corrupt_idx;
  bit         rx_hold;
  bit         done_seen;
  int         done_cyc;
  logic       s_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nxt_pat(input logic m, input logic [7:0] p);
    if (m) return (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
    return p + 8'd1;
  endfunction

  // One clock: sample at negedge, then update the FIFO model just after posedge.
  task automatic tick();
    logic [7:0] w;
    @(negedge clk);
    cyc++;
    s_done = done;
    if (u_if.wr_uart || u_if.rd_uart) chk("strobe_busy", busy, 1);
    if (u_if.tx_full) chk("wr_while_full", u_if.wr_uart, 0);
    if (u_if.wr_uart) begin
      if (exp_q.size() == 0) chk("tx_extra", u_if.wr_uart, 0);
      else chk("tx_word", u_if.w_data, exp_q.pop_front());
      w = u_if.w_data;
      if (sent_n == corrupt_idx) w = w ^ 8'h01;
      if (!rx_hold) begin
        line_d.push_back(w);
        line_t.push_back(cyc + LineLat);
      end
      sent_n++;
    end
    if (u_if.rd_uart) begin
      if (rx_q.size() == 0) chk("rd_empty", u_if.rd_uart, 0);
      else void'(rx_q.pop_front());
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      chk("busy_in_fin", busy, 1);
    end
    @(posedge clk);
    #1;
    while (line_t.size() > 0 && line_t[0] <= cyc) begin
      rx_q.push_back(line_d.pop_front());
      void'(line_t.pop_front());
    end
    u_if.rx_empty = (rx_q.size() == 0);
    u_if.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic chk_first_err(input logic [7:0] e_idx, input logic [7:0] e_exp,
                               input logic [7:0] e_got);
`ifdef UART_LT_FIRST_ERR_EN
    chk("fe_idx", fe_idx, e_idx);
    chk("fe_exp", fe_exp, e_exp);
    chk("fe_got", fe_got, e_got);
`else
    chk("fe_idx_tied", fe_idx, 0);
    chk("fe_exp_tied", fe_exp, 0);
    chk("fe_got_tied", fe_got, 0);
    if (e_idx != e_exp) n_chk += 0;
    if (e_got != 8'h00) n_chk += 0;
`endif
  endtask

  task automatic run(input logic m, input int len, input int corrupt, input bit hold,
                     input int full_at, input bit poke, input int rst_at,
                     input logic exp_pass, input logic exp_tmo, input int exp_err,
                     input logic [7:0] e_idx, input logic [7:0] e_exp, input logic [7:0] e_got);
    logic [7:0] p;
    int         start_cyc;
    bit         full_done;
    bit         poked;
    full_done = 1'b0;
    poked     = 1'b0;
    exp_q.delete();
    line_d.delete();
    line_t.delete();
    rx_q.delete();
    u_if.rx_empty = 1'b1;
    u_if.r_data   = 8'h00;
    sent_n      = 0;
    corrupt_idx = corrupt;
    rx_hold     = hold;
    done_seen   = 1'b0;
    p = 8'h01;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(p);
      p = nxt_pat(m, p);
    end
    mode      = m;
    burst_len = 8'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 3000 && !done_seen; n++) begin
      if (full_at >= 0 && !full_done && sent_n == full_at) begin
        u_if.tx_full = 1'b1;
        repeat (50) tick();
        u_if.tx_full = 1'b0;
        full_done = 1'b1;
      end else if (poke && !poked && sent_n == 8) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        poked = 1'b1;
      end else if (rst_at >= 0 && sent_n == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_wr", u_if.wr_uart, 0);
        chk("rst_rd", u_if.rd_uart, 0);
        chk("rst_wdata", u_if.w_data, 0);
        chk_first_err(8'h00, 8'h00, 8'h00);
        repeat (30) tick();
        chk("rst_no_done", done_seen, 0);
        return;
      end else begin
        tick();
      end
    end
    chk("done_seen", done_seen, 1);
    chk("pass", pass, exp_pass);
    chk("timeout", tmo, exp_tmo);
    chk("err_cnt", err_cnt, exp_err);
    chk("tx_all_sent", exp_q.size(), 0);
    chk_first_err(e_idx, e_exp, e_got);
    if (exp_tmo) chk("timeout_latency", done_cyc - (start_cyc + 1), Timeout);
    if (len == 0) chk("zero_len_latency", done_cyc - start_cyc, 2);
    tick();
    chk("done_one_cycle", s_done, 0);
    chk("idle_after_fin", busy, 0);
    chk("pass_holds", pass, exp_pass);
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    cyc          = 0;
    sent_n       = 0;
    corrupt_idx  = -1;
    rx_hold      = 1'b0;
    done_seen    = 1'b0;
    done_cyc     = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    mode         = 1'b0;
    burst_len    = 8'd0;
    u_if.tx_full  = 1'b0;
    u_if.rx_empty = 1'b1;
    u_if.r_data   = 8'h00;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_tmo", tmo, 0);
    chk("reset_err", err_cnt, 0);
    chk("reset_wr", u_if.wr_uart, 0);
    chk("reset_rd", u_if.rd_uart, 0);
    chk("reset_wdata", u_if.w_data, 0);
    chk_first_err(8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();

    // counter loopback, 16 words
    run(1'b0, 16, -1, 1'b0, -1, 1'b0, -1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    // LFSR loopback, 4 words: 01 B8 5C 2E
    run(1'b1, 4, -1, 1'b0, -1, 1'b0, -1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    // third word corrupted on the line
    run(1'b0, 8, 2, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0, 1, 8'd2, 8'h03, 8'h02);
    // RX line dead: timeout
    run(1'b0, 4, -1, 1'b1, -1, 1'b0, -1, 1'b0, 1'b1, 0, 8'h00, 8'h00, 8'h00);
    // TX FIFO full for 50 cycles mid-burst, plus a start pulse while busy
    run(1'b0, 16, -1, 1'b0, 5, 1'b1, -1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    // reset at word 5 of 16
    run(1'b0, 16, -1, 1'b0, -1, 1'b0, 5, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    // fresh run after the abort
    run(1'b0, 16, -1, 1'b0, -1, 1'b0, -1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    // zero-length burst
    run(1'b1, 0, -1, 1'b0, -1, 1'b0, -1, 1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
